// File: rtl/div_ctrl.sv
// Multi-cycle restoring divide sequencer for EX: signed/unsigned DATA_W-bit
// divide, one quotient bit per cycle, with a stall request held until ready.
module div_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  stall_req_o
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     dsr_q, dsr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_q_q, neg_q_d;
  logic                  neg_r_q, neg_r_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  // Operand magnitudes; 0x80000000 negates to itself and is read as unsigned.
  logic                  sign1, sign2;
  logic [DATA_W-1:0]     abs1, abs2;

  assign sign1 = signed_i & opdata1_i[DATA_W-1];
  assign sign2 = signed_i & opdata2_i[DATA_W-1];
  assign abs1  = sign1 ? DATA_W'(-opdata1_i) : opdata1_i;
  assign abs2  = sign2 ? DATA_W'(-opdata2_i) : opdata2_i;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  logic [DATA_W:0]       rem_ext;
  logic [DATA_W:0]       trial;
  logic                  trial_neg;
  logic [DATA_W-1:0]     rem_step;
  logic [DATA_W-1:0]     quo_step;

  assign rem_ext   = {rem_q, quo_q[DATA_W-1]};
  assign trial     = rem_ext - {1'b0, dsr_q};
  assign trial_neg = trial[DATA_W];
  assign rem_step  = trial_neg ? rem_ext[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_step  = {quo_q[DATA_W-2:0], ~trial_neg};

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = '0;
    ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = RUN;
            quo_d   = abs1;
            dsr_d   = abs2;
            rem_d   = '0;
            cnt_d   = '0;
            neg_q_d = sign1 ^ sign2;
            neg_r_d = sign1;
          end
        end
      end

      BYZERO: begin
        if (annul_i || !start_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
        end
      end

      RUN: begin
        if (annul_i || !start_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {(neg_r_q ? DATA_W'(-rem_step) : rem_step),
                        (neg_q_q ? DATA_W'(-quo_step) : quo_step)};
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

  // Combinational so EX is released in the same cycle the result appears.
  assign stall_req_o = start_i & ~annul_i & ~ready_q & ~rst;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, stall/busy timing, sign handling,
// divide-by-zero, annul, back-to-back and asynchronous reset.
module tb_div_ctrl;

  localparam int unsigned DATA_W = 32;

  logic                 clk;
  logic                 rst;
  logic                 start_i;
  logic                 signed_i;
  logic [DATA_W-1:0]    opdata1_i;
  logic [DATA_W-1:0]    opdata2_i;
  logic                 annul_i;
  logic [2*DATA_W-1:0]  result_o;
  logic                 ready_o;
  logic                 busy_o;
  logic                 stall_req_o;

  int n_cmp = 0;
  int n_err = 0;

  div_ctrl #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .stall_req_o (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request in a new cycle 0 (just after the clock edge).
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
  endtask

  // Called at edge+1 of cycle 0; returns mid-cycle of the ready cycle.
  task automatic await_ready(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int  cyc;
    bit  stall_ok;
    bit  busy_ok;
    stall_ok = 1'b1;
    busy_ok  = 1'b1;
    #4;
    chk({tag, "_stall_c0"}, 64'(stall_req_o), 64'd1);
    chk({tag, "_busy_c0"}, 64'(busy_o), 64'd0);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #5;
      cyc = i;
      if (ready_o) break;
      if (stall_req_o !== 1'b1) stall_ok = 1'b0;
      if (busy_o !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_stall_rdy"}, 64'(stall_req_o), 64'd0);
    chk({tag, "_busy_rdy"}, 64'(busy_o), 64'd1);
    chk({tag, "_stall_run"}, 64'(stall_ok), 64'd1);
    chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic single(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] res);
    issue(sgn, a, b);
    await_ready(tag, lat, res);
    start_i = 1'b0;
    @(posedge clk); #5;
    chk({tag, "_after_rdy"}, {62'd0, ready_o, busy_o}, 64'd0);
    chk({tag, "_res_clr"}, result_o, 64'd0);
  endtask

  initial begin
    bit no_rdy;
    rst       = 1'b1;
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    annul_i   = 1'b0;
    #2;
    chk("rst_result", result_o, 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    single("u100_7",   1'b0, 32'd100,       32'd7,         33, {32'h2, 32'hE});
    single("s-7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    single("s7_-2",    1'b1, 32'd7,         32'hFFFFFFFE,  33, {32'h1, 32'hFFFFFFFD});
    single("smin_-1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  33, {32'h0, 32'h80000000});
    single("umin_max", 1'b0, 32'h80000000,  32'hFFFFFFFF,  33, {32'h80000000, 32'h0});
    single("umax_1",   1'b0, 32'hFFFFFFFF,  32'd1,         33, {32'h0, 32'hFFFFFFFF});
    single("u_div0",   1'b0, 32'd100,       32'd0,         2,  64'd0);
    single("s_div0",   1'b1, 32'hFFFFFFFB,  32'd0,         2,  64'd0);

    // annul pulsed in RUN cycle 10
    issue(1'b0, 32'd1000, 32'd3);
    for (int i = 1; i <= 10; i++) @(posedge clk);
    #1;
    annul_i = 1'b1;
    #4;
    chk("annul_stall", 64'(stall_req_o), 64'd0);
    chk("annul_busy_c10", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    #4;
    chk("annul_idle_c11", {62'd0, ready_o, busy_o}, 64'd0);
    no_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #5;
      if (ready_o !== 1'b0) no_rdy = 1'b0;
    end
    chk("annul_no_ready", 64'(no_rdy), 64'd1);
    single("u9_3", 1'b0, 32'd9, 32'd3, 33, {32'h0, 32'h3});

    // back-to-back with start held throughout
    issue(1'b0, 32'd50, 32'd5);
    await_ready("b2b_first", 33, {32'h0, 32'd10});
    opdata1_i = 32'd51;
    @(posedge clk); #1;
    await_ready("b2b_second", 33, {32'h1, 32'd10});
    start_i = 1'b0;
    @(posedge clk); #5;

    // asynchronous reset in RUN cycle 15
    issue(1'b0, 32'd100, 32'd7);
    for (int i = 1; i <= 15; i++) @(posedge clk);
    #3;
    chk("prerst_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_result", result_o, 64'd0);
    chk("midrst_flags", {61'd0, ready_o, busy_o, stall_req_o}, 64'd0);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst_ready", 64'(ready_o), 64'd0);
    single("u20_6", 1'b0, 32'd20, 32'd6, 33, {32'h2, 32'h3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer for the EX stage. It accepts a signed or unsigned 32-bit divide request, iterates one quotient bit per cycle, and holds the pipeline through a stall request until the result is ready. It is instantiated beside the ALU in EX. Its stall request feeds the pipeline controller's stall bus, and its 64-bit result is written to HI/LO downstream.

## Interface
- DATA_W, 32, operand width; the iteration count equals DATA_W.
- clk  in  1  pipeline clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start_i  in  1  divide request from EX; level, held while EX is stalled
- signed_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1_i  in  DATA_W  dividend; sampled with start
- opdata2_i  in  DATA_W  divisor; sampled with start
- annul_i  in  1  cancel the in-flight divide (flush/exception)
- result_o  out  2*DATA_W  {remainder, quotient}; upper half goes to HI, lower half to LO
- ready_o  out  1  result valid, one-cycle pulse
- busy_o  out  1  state != IDLE
- stall_req_o  out  1  stall request to the pipeline controller

## Operation
- States: IDLE, BYZERO, RUN, DONE. Reset places the block in IDLE.
- IDLE:
  - start_i=1 & annul_i=0 & opdata2_i=0 -> BYZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 -> RUN. On this transition:
    - latch |dividend| and |divisor| (absolute values only when signed_i=1);
    - latch neg_q = signed & (sign1 xor sign2) and neg_r = signed & sign1;
    - clear the partial remainder and the iteration counter.
  - Otherwise stay in IDLE.
- RUN, one restoring step per cycle:
  - shift {rem, quo} left 1 and bring in the next dividend bit;
  - trial = rem - divisor, computed DATA_W+1 bits wide;
  - if trial >= 0, rem = trial and quotient bit = 1; else quotient bit = 0;
  - the counter increments; after the DATA_W-th step -> DONE.
- BYZERO: one cycle -> DONE with quotient = 0 and remainder = 0.
- DONE: ready_o=1 and result_o valid. Always returns to IDLE on the next cycle. start_i is ignored in DONE, so back-to-back divides get one IDLE cycle between them.
- Abort: in BYZERO or RUN, if annul_i=1 or start_i=0 -> IDLE next cycle. No ready_o pulse; partial state is discarded.
- Sign fix-up, applied when loading the result on entry to DONE:
  - quotient is negated if neg_q;
  - remainder is negated if neg_r.
- Width rules:
  - |-2^31| = 0x80000000, handled as unsigned.
  - -2^31 / -1 yields quotient 0x80000000 (truncated to DATA_W) and remainder 0.
- stall_req_o = start_i & ~annul_i & ~ready_o & ~rst. This is combinational, so the stall drops in the same cycle ready_o rises and EX advances with the result.
- result_o = 0 in every state except DONE.

## Timing
- Reset (async assert): state=IDLE, all internal registers 0, result_o=0, ready_o=0, busy_o=0, stall_req_o=0.
- Deassert of rst is synchronous to clk; the first start is accepted on the first clk edge after deassert.
- Latency, counting the cycle start_i is first sampled in IDLE as cycle 0:
  - normal divide: RUN occupies cycles 1..DATA_W; ready_o is high in cycle DATA_W+1 (33 by default);
  - divide by zero: ready_o is high in cycle 2.
- stall_req_o is high in cycles 0..DATA_W and low in the ready cycle.
- Operand changes after cycle 0 have no effect on the result.
- annul_i together with start_i in IDLE: no start.
- Reset mid-RUN: immediate IDLE; no ready_o pulse.

## Test plan
- Unsigned 100 / 7 (start held): ready_o in cycle 33, result_o = {0x00000002, 0x0000000E}; stall_req_o high cycles 0..32 and low in cycle 33.
- Signed -7 / 2: result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 0x80000000 / 0xFFFFFFFF: result_o = {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1: result_o = {0, 0xFFFFFFFF}.
- Divisor 0 (signed and unsigned): ready_o in cycle 2, result_o = 0, busy_o high in cycles 1..2.
- annul_i pulsed in RUN cycle 10: IDLE in cycle 11, no ready_o, stall_req_o low while annul_i is high. A fresh 9 / 3 afterwards returns {0, 3} in 33 cycles.
- Back-to-back 50 / 5 then 51 / 5 with start_i held continuously: first ready gives {0, 10}; one IDLE cycle follows; second ready arrives 33 cycles later with {1, 10}.
- rst asserted mid-RUN (cycle 15) asynchronously, between clock edges: outputs zero immediately, no ready_o. After deassert, a 20 / 6 request completes normally with {2, 3}.
